// File: rtl/lsu_arbiter.sv
// Two-master arbiter in front of a single LSU port: m0 normally wins, m1 is
// protected by a starvation counter and may lock the bus for bounded bursts.
module lsu_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int MAX_LOCK     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [15:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    input  logic [3:0]  m0_bmask,
    input  logic [2:0]  m0_ld_sel,
    input  logic        m1_req,
    input  logic [15:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    input  logic [3:0]  m1_bmask,
    input  logic [2:0]  m1_ld_sel,
    input  logic        m1_lock,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic [15:0] lsu_addr,
    output logic [31:0] lsu_wdata,
    output logic        lsu_wr_en,
    output logic [3:0]  lsu_bmask,
    output logic [2:0]  lsu_ld_sel,
    input  logic [31:0] lsu_rdata,
    output logic [1:0]  o_dbg_state
);

    // Handshake: mX_req is a valid that must be held until accepted; mX_gnt is
    // the same-cycle ready, and the access transfers on any edge with req & gnt.

    typedef enum logic [1:0] {
        ST_ARB  = 2'b00,
        ST_LOCK = 2'b01,
        ST_COOL = 2'b10
    } state_t;

    localparam logic [7:0] L_STARVE = STARVE_LIMIT[7:0];
    localparam logic [7:0] L_MAX    = MAX_LOCK[7:0];

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_starve;
    logic [7:0]  r_lock_cnt;
    logic [7:0]  w_lock_inc;
    logic        w_m0_gnt;
    logic        w_m1_gnt;
    logic        w_locked_req;
    logic        r_m0_rvalid;
    logic        r_m1_rvalid;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;

    assign w_lock_inc   = r_lock_cnt + 8'd1;
    assign w_locked_req = m1_req & m1_lock;

    always_comb begin
        w_m0_gnt = 1'b0;
        w_m1_gnt = 1'b0;
        w_next   = ST_ARB;
        if (rst) begin
            case (r_state)
                ST_ARB: begin
                    if (m1_req && (r_starve >= L_STARVE || !m0_req)) begin
                        w_m1_gnt = 1'b1;
                    end else begin
                        w_m0_gnt = m0_req;
                    end
                    if (w_m1_gnt && m1_lock) begin
                        w_next = ST_LOCK;
                    end
                end
                // m0 is shut out for the whole lock, including the release cycle.
                ST_LOCK: begin
                    w_m1_gnt = m1_req;
                    if (w_locked_req) begin
                        w_next = (w_lock_inc >= L_MAX) ? ST_COOL : ST_LOCK;
                    end
                end
                ST_COOL: begin
                    w_m0_gnt = m0_req;
                end
                default: begin
                    w_next = ST_ARB;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_ARB;
            r_starve    <= 8'd0;
            r_lock_cnt  <= 8'd0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= 32'd0;
            r_m1_rdata  <= 32'd0;
        end else begin
            r_state <= w_next;

            if (m1_req && !w_m1_gnt) begin
                r_starve <= (r_starve >= L_STARVE) ? L_STARVE : r_starve + 8'd1;
            end else begin
                r_starve <= 8'd0;
            end

            if (r_state == ST_ARB && w_m1_gnt && m1_lock) begin
                r_lock_cnt <= 8'd1;
            end else if (r_state == ST_LOCK && w_locked_req) begin
                r_lock_cnt <= w_lock_inc;
            end else begin
                r_lock_cnt <= 8'd0;
            end

            r_m0_rvalid <= w_m0_gnt & ~m0_we;
            r_m1_rvalid <= w_m1_gnt & ~m1_we;
            if (w_m0_gnt && !m0_we) begin
                r_m0_rdata <= lsu_rdata;
            end
            if (w_m1_gnt && !m1_we) begin
                r_m1_rdata <= lsu_rdata;
            end
        end
    end

    always_comb begin
        lsu_addr   = 16'd0;
        lsu_wdata  = 32'd0;
        lsu_wr_en  = 1'b0;
        lsu_bmask  = 4'd0;
        lsu_ld_sel = 3'b010;
        if (w_m0_gnt) begin
            lsu_addr   = m0_addr;
            lsu_wdata  = m0_wdata;
            lsu_wr_en  = m0_we;
            lsu_bmask  = m0_bmask;
            lsu_ld_sel = m0_ld_sel;
        end else if (w_m1_gnt) begin
            lsu_addr   = m1_addr;
            lsu_wdata  = m1_wdata;
            lsu_wr_en  = m1_we;
            lsu_bmask  = m1_bmask;
            lsu_ld_sel = m1_ld_sel;
        end
    end

    assign m0_gnt      = w_m0_gnt;
    assign m1_gnt      = w_m1_gnt;
    assign m0_rvalid   = r_m0_rvalid;
    assign m1_rvalid   = r_m1_rvalid;
    assign m0_rdata    = r_m0_rdata;
    assign m1_rdata    = r_m1_rdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: directed scenarios plus randomized traffic, all
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_lsu_arbiter;

    localparam int STARVE_LIMIT = 8;
    localparam int MAX_LOCK     = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req, m0_we, m1_we, m1_lock;
    logic [15:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata, lsu_rdata;
    logic [3:0]  m0_bmask, m1_bmask;
    logic [2:0]  m0_ld_sel, m1_ld_sel;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, lsu_wr_en;
    logic [31:0] m0_rdata, m1_rdata, lsu_wdata;
    logic [15:0] lsu_addr;
    logic [3:0]  lsu_bmask;
    logic [2:0]  lsu_ld_sel;
    logic [1:0]  dbg_state;

    lsu_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_bmask(m0_bmask), .m0_ld_sel(m0_ld_sel),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_bmask(m1_bmask), .m1_ld_sel(m1_ld_sel), .m1_lock(m1_lock),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wr_en(lsu_wr_en),
        .lsu_bmask(lsu_bmask), .lsu_ld_sel(lsu_ld_sel), .lsu_rdata(lsu_rdata),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: starvation count, lock run length, cool-down flag.
    int          mdl_starve = 0;
    int          mdl_run    = 0;
    bit          mdl_locked = 1'b0;
    bit          mdl_cool   = 1'b0;
    bit          exp_rv0    = 1'b0;
    bit          exp_rv1    = 1'b0;
    logic [31:0] exp_rd0    = 32'd0;
    logic [31:0] exp_rd1    = 32'd0;
    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];
    bit          obs_g0, obs_g1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        rst = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
        m0_we = 1'b0;  m1_we = 1'b0;
        m0_addr = 16'd0; m1_addr = 16'd0;
        m0_wdata = 32'd0; m1_wdata = 32'd0;
        m0_bmask = 4'd0; m1_bmask = 4'd0;
        m0_ld_sel = 3'd0; m1_ld_sel = 3'd0;
        lsu_rdata = 32'd0;
    endtask

    // Inputs are already driven (at the falling edge); check, clock, update model.
    task automatic run_cycle();
        bit          g0, g1;
        logic [15:0] ea;
        logic [31:0] ew;
        logic        ewe;
        logic [3:0]  eb;
        logic [2:0]  es;
        logic [31:0] qd;
        #1;
        check_eq("m0_rvalid", m0_rvalid, exp_rv0);
        check_eq("m1_rvalid", m1_rvalid, exp_rv1);
        check_eq("m0_rdata", m0_rdata, exp_rd0);
        check_eq("m1_rdata", m1_rdata, exp_rd1);
        if (m0_rvalid === 1'b1) begin
            check_eq("m0_q_nonempty", exp0_q.size(), (exp0_q.size() == 0) ? 1 : exp0_q.size());
            if (exp0_q.size() != 0) begin
                qd = exp0_q.pop_front();
                check_eq("m0_q_data", m0_rdata, qd);
            end
        end
        if (m1_rvalid === 1'b1) begin
            check_eq("m1_q_nonempty", exp1_q.size(), (exp1_q.size() == 0) ? 1 : exp1_q.size());
            if (exp1_q.size() != 0) begin
                qd = exp1_q.pop_front();
                check_eq("m1_q_data", m1_rdata, qd);
            end
        end

        g0 = 1'b0;
        g1 = 1'b0;
        if (rst) begin
            if (mdl_cool) g0 = m0_req;
            else if (mdl_locked) g1 = m1_req;
            else if (m1_req && (mdl_starve >= STARVE_LIMIT || !m0_req)) g1 = 1'b1;
            else g0 = m0_req;
        end
        ea = 16'd0; ew = 32'd0; ewe = 1'b0; eb = 4'd0; es = 3'b010;
        if (g0) begin
            ea = m0_addr; ew = m0_wdata; ewe = m0_we; eb = m0_bmask; es = m0_ld_sel;
        end else if (g1) begin
            ea = m1_addr; ew = m1_wdata; ewe = m1_we; eb = m1_bmask; es = m1_ld_sel;
        end
        check_eq("m0_gnt", m0_gnt, g0);
        check_eq("m1_gnt", m1_gnt, g1);
        check_eq("lsu_addr", lsu_addr, ea);
        check_eq("lsu_wdata", lsu_wdata, ew);
        check_eq("lsu_wr_en", lsu_wr_en, ewe);
        check_eq("lsu_bmask", lsu_bmask, eb);
        check_eq("lsu_ld_sel", lsu_ld_sel, es);
        obs_g0 = m0_gnt;
        obs_g1 = m1_gnt;

        @(posedge clk);
        if (!rst) begin
            mdl_starve = 0; mdl_run = 0; mdl_locked = 1'b0; mdl_cool = 1'b0;
            exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_rd0 = 32'd0; exp_rd1 = 32'd0;
            exp0_q.delete();
            exp1_q.delete();
        end else begin
            exp_rv0 = g0 && !m0_we;
            exp_rv1 = g1 && !m1_we;
            if (exp_rv0) begin exp_rd0 = lsu_rdata; exp0_q.push_back(lsu_rdata); end
            if (exp_rv1) begin exp_rd1 = lsu_rdata; exp1_q.push_back(lsu_rdata); end
            if (m1_req && !g1) mdl_starve = (mdl_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : mdl_starve + 1;
            else mdl_starve = 0;
            if (mdl_cool) begin
                mdl_cool = 1'b0;
            end else if (mdl_locked) begin
                if (m1_req && m1_lock) begin
                    mdl_run++;
                    if (mdl_run >= MAX_LOCK) begin
                        mdl_locked = 1'b0;
                        mdl_cool   = 1'b1;
                    end
                end else begin
                    mdl_locked = 1'b0;
                end
            end else if (g1 && m1_lock) begin
                mdl_locked = 1'b1;
                mdl_run    = 1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int n0, n1, first1;
        int p0, p1, pl;
        set_idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state: no grants, default LSU drive, no read data.
        m0_req = 1'b1; m1_req = 1'b1;
        run_cycle();
        set_idle();
        run_cycle();

        // Both requesting, no lock: m1 wins every ninth cycle.
        n0 = 0; n1 = 0; first1 = -1;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 27; i++) begin
            run_cycle();
            n0 += obs_g0;
            n1 += obs_g1;
            if (obs_g1 && first1 < 0) first1 = i;
        end
        check_eq("starve_m0_cnt", n0, 24);
        check_eq("starve_m1_cnt", n1, 3);
        check_eq("starve_first_m1", first1, 8);
        set_idle();
        run_cycle();

        // m0 load, then m1 load in the adjacent cycle.
        m0_req = 1'b1; m0_addr = 16'h0010; m0_ld_sel = 3'b001; lsu_rdata = 32'hDEADBEEF;
        run_cycle();
        set_idle();
        m1_req = 1'b1; m1_addr = 16'h0020; m1_ld_sel = 3'b100; lsu_rdata = 32'h12345678;
        run_cycle();
        set_idle();
        run_cycle();
        run_cycle();

        // m1 store: write enable and byte mask pass through, no read data.
        m1_req = 1'b1; m1_we = 1'b1; m1_bmask = 4'b0011; m1_wdata = 32'h0000ABCD; m1_addr = 16'h4000;
        run_cycle();
        set_idle();
        run_cycle();

        // Lock burst with m0 waiting: 16 m1 grants, one cool-down m0 grant.
        n1 = 0;
        m1_req = 1'b1; m1_lock = 1'b1;
        for (int i = 0; i < 20; i++) begin
            m0_req = (i != 0);
            run_cycle();
            if (i < 16) n1 += obs_g1;
            if (i == 16) check_eq("cool_m0_gnt", obs_g0, 1);
        end
        check_eq("lock_m1_cnt", n1, 16);
        set_idle();
        run_cycle();

        // Reset while locked with a load in flight, then immediate m0 grant.
        m1_req = 1'b1; m1_lock = 1'b1; lsu_rdata = 32'hCAFEF00D;
        run_cycle();
        run_cycle();
        rst = 1'b0;
        run_cycle();
        set_idle();
        m0_req = 1'b1;
        run_cycle();
        check_eq("post_reset_m0_gnt", obs_g0, 1);
        set_idle();
        run_cycle();

        // Randomized traffic in segments with varying request/lock pressure.
        for (int seg = 0; seg < 80; seg++) begin
            p0 = $urandom_range(0, 100);
            p1 = $urandom_range(40, 100);
            pl = ($urandom_range(0, 1) == 1) ? 100 : $urandom_range(0, 100);
            for (int i = 0; i < 40; i++) begin
                rst       = ($urandom_range(0, 199) != 0);
                m0_req    = ($urandom_range(1, 100) <= p0);
                m1_req    = ($urandom_range(1, 100) <= p1);
                m1_lock   = ($urandom_range(1, 100) <= pl);
                m0_we     = $urandom_range(0, 1);
                m1_we     = $urandom_range(0, 1);
                m0_addr   = 16'($urandom);
                m1_addr   = 16'($urandom);
                m0_wdata  = $urandom;
                m1_wdata  = $urandom;
                m0_bmask  = 4'($urandom_range(0, 15));
                m1_bmask  = 4'($urandom_range(0, 15));
                m0_ld_sel = 3'($urandom_range(0, 4));
                m1_ld_sel = 3'($urandom_range(0, 4));
                lsu_rdata = $urandom;
                run_cycle();
            end
        end

        set_idle();
        run_cycle();
        run_cycle();
        check_eq("q0_drained", exp0_q.size(), 0);
        check_eq("q1_drained", exp1_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
